psel_rr_arb: RTL and testbench

Parametrised N-requester priority selector with registered one-hot grant, fixed or round-robin priority, and grant ownership that persists across cycles. Generalises the 2/4/8-bit combinational selector tree into a sequential arbiter that shares functional units and CDB ports among N requesters. Sits between request sources (RS entries, FU issue slots) and the shared resource.

---
 rtl/psel_rr_arb.sv | 184 ++++++++++++++++++
 tb/tb_psel_rr_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psel_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : psel_rr_arb
// Purpose  : N-requester arbiter with a registered one-hot grant. Priority is
//            either fixed (highest index wins) or rotating (round-robin).
//            Ownership persists while the owner keeps requesting; a contested
//            owner is preempted after MAX_HOLD consecutive cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   N           number of requesters (>= 2)
//   ROUND_ROBIN 0 = fixed priority, 1 = rotating priority
//   MAX_HOLD    max consecutive cycles for a contested owner, 0 = unlimited
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   en         in   arbitration enable
//   req        in   [N]          request vector
//   gnt        out  [N]          registered one-hot grant (zero when idle)
//   gnt_idx    out  [clog2(N)]   index of granted requester (0 when idle)
//   gnt_valid  out               high when gnt is nonzero
//   gnt_count  out  [N*16]       per-requester new-grant counters
//                                (present only with PSEL_PERF_CNT_EN)
//   req_up     out               combinational OR of req, ignores en
// Build option:
//   PSEL_PERF_CNT_EN  adds saturating 16-bit per-requester grant counters.
// ============================================================================
module psel_rr_arb #(
  parameter int N           = 8,
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_HOLD    = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
`ifdef PSEL_PERF_CNT_EN
  output logic [N*16-1:0]      gnt_count,
`endif
  output logic                 req_up
);

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam bit            c_hold_en   = (MAX_HOLD > 0);
  localparam logic [HW-1:0] c_hold_last = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [IW-1:0] c_ptr_init  = IW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_gnt;
  logic [IW-1:0] r_gnt_idx;
  logic          r_gnt_valid;
  logic [IW-1:0] r_ptr;
  logic [HW-1:0] r_hold;

  logic [IW:0]   w_sel_all;
  logic [IW:0]   w_sel_oth;
  logic          w_preempt_ok;
  logic          w_new;
  logic          w_idle;
  logic [IW-1:0] w_new_idx;
  logic [N-1:0]  w_new_onehot;

  // Scan v starting at index 'start' and moving downward, wrapping from 0 to
  // N-1. Returns {found, index}. Fixed priority simply keeps start at N-1.
  function automatic logic [IW:0] f_select(input logic [N-1:0] v,
                                           input logic [IW-1:0] start);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] pos_i;
    int            pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) - k;
      if (pos < 0) pos = pos + N;
      pos_i = IW'(pos);
      if (!found && v[pos_i]) begin
        found = 1'b1;
        idx   = pos_i;
      end
    end
    return {found, idx};
  endfunction

  assign w_sel_all = f_select(req, r_ptr);
  assign w_sel_oth = f_select(req & ~r_gnt, r_ptr);

  // Preemption fires on the last allowed hold cycle, and only when some
  // other requester is actually waiting.
  assign w_preempt_ok = c_hold_en && (r_hold == c_hold_last) && w_sel_oth[IW];

  always_comb begin
    w_new     = 1'b0;
    w_idle    = 1'b0;
    w_new_idx = w_sel_all[IW-1:0];
    case (r_state)
      S_IDLE: begin
        if (en && w_sel_all[IW]) w_new  = 1'b1;
        else                     w_idle = 1'b1;
      end
      S_GRANT: begin
        if (!en) begin
          w_idle = 1'b1;
        end else if (!req[r_gnt_idx]) begin
          // Owner released: the owner bit is clear, so any hit is another requester.
          if (w_sel_all[IW]) w_new  = 1'b1;
          else               w_idle = 1'b1;
        end else if (w_preempt_ok) begin
          w_new     = 1'b1;
          w_new_idx = w_sel_oth[IW-1:0];
        end
      end
      default: w_idle = 1'b1;
    endcase
  end

  always_comb begin
    w_new_onehot            = '0;
    w_new_onehot[w_new_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_ptr       <= c_ptr_init;
      r_hold      <= '0;
    end else if (w_new) begin
      r_state     <= S_GRANT;
      r_gnt       <= w_new_onehot;
      r_gnt_idx   <= w_new_idx;
      r_gnt_valid <= 1'b1;
      r_hold      <= '0;
      // Rotating mode: the new owner drops to lowest priority next round.
      if (ROUND_ROBIN != 0) begin
        r_ptr <= (w_new_idx == '0) ? c_ptr_init : (w_new_idx - 1'b1);
      end
    end else if (w_idle) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_hold      <= '0;
    end else begin
      // Owner keeps the grant; count held cycles, saturating at the last
      // allowed value (stays 0 when holding is unlimited).
      if (r_hold != c_hold_last) r_hold <= r_hold + 1'b1;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign req_up    = |req;

`ifdef PSEL_PERF_CNT_EN
  // Counts new grants only; hold cycles do not advance a counter.
  for (genvar gi = 0; gi < N; gi++) begin : g_perf_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (w_new && (w_new_idx == IW'(gi)) && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign gnt_count[gi*16 +: 16] = r_cnt;
  end : g_perf_cnt
`endif

endmodule
`default_nettype wire

// File: tb/tb_psel_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_psel_rr_arb
// Purpose  : Self-checking bench for psel_rr_arb. Drives a rotating-priority
//            instance and a fixed-priority instance from shared inputs and
//            checks both against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psel_rr_arb;

  localparam int N    = 8;
  localparam int MAXH = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         en;
  logic [N-1:0] req;

  logic [N-1:0] gnt_rr, gnt_fx;
  logic [2:0]   idx_rr, idx_fx;
  logic         v_rr, v_fx, up_rr, up_fx;
`ifdef PSEL_PERF_CNT_EN
  logic [N*16-1:0] cnt_rr, cnt_fx;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = rotating instance, 1 = fixed instance.
  // owner = -1 means nothing granted; held = cycles the owner has had gnt.
  int m_owner[2];
  int m_held[2];
  int m_ptr[2];
  int m_cnt[N];

  always #5 clock = ~clock;

  psel_rr_arb #(.N(N), .ROUND_ROBIN(1), .MAX_HOLD(MAXH)) dut_rr (
    .clock(clock), .reset_n(reset_n), .en(en), .req(req),
    .gnt(gnt_rr), .gnt_idx(idx_rr), .gnt_valid(v_rr),
`ifdef PSEL_PERF_CNT_EN
    .gnt_count(cnt_rr),
`endif
    .req_up(up_rr)
  );

  psel_rr_arb #(.N(N), .ROUND_ROBIN(0), .MAX_HOLD(MAXH)) dut_fx (
    .clock(clock), .reset_n(reset_n), .en(en), .req(req),
    .gnt(gnt_fx), .gnt_idx(idx_fx), .gnt_valid(v_fx),
`ifdef PSEL_PERF_CNT_EN
    .gnt_count(cnt_fx),
`endif
    .req_up(up_fx)
  );

  // ---------------- reference model ----------------
  function automatic int pick(int mode, logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mode == 0) ? ((m_ptr[mode] - k + N) % N) : (N - 1 - k);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_held[m]  = 0;
      m_ptr[m]   = N - 1;
    end
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_grant(int mode, int k);
    m_owner[mode] = k;
    m_held[mode]  = 1;
    if (mode == 0) begin
      m_ptr[0] = (k + N - 1) % N;
      if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic model_step(int mode, logic e, logic [N-1:0] r);
    int           o;
    logic [N-1:0] others;
    o = m_owner[mode];
    if (!e) begin
      m_owner[mode] = -1;
      m_held[mode]  = 0;
    end else if (o < 0) begin
      if (r != '0) model_grant(mode, pick(mode, r));
    end else if (!r[o]) begin
      if (r != '0) model_grant(mode, pick(mode, r));
      else begin
        m_owner[mode] = -1;
        m_held[mode]  = 0;
      end
    end else begin
      others    = r;
      others[o] = 1'b0;
      if (m_held[mode] >= MAXH && others != '0) model_grant(mode, pick(mode, others));
      else m_held[mode] = m_held[mode] + 1;
    end
  endtask

  function automatic logic [N+3:0] exp_out(int mode);
    logic [N-1:0] g;
    logic [2:0]   ix;
    g  = '0;
    ix = '0;
    if (m_owner[mode] >= 0) begin
      g[m_owner[mode]] = 1'b1;
      ix = 3'(m_owner[mode]);
    end
    return {g, ix, (m_owner[mode] >= 0)};
  endfunction

  // One clock: inputs are sampled at the edge, outputs checked 1 ns later.
  task automatic cycle();
    logic         e;
    logic [N-1:0] r;
    e = en;
    r = req;
    @(posedge clock);
    model_step(0, e, r);
    model_step(1, e, r);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b0;
    req     = '0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    req     = 8'hFF;
    en      = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      n_vec++;
      if ({gnt_rr, idx_rr, v_rr, up_rr} !== {8'h00, 3'd0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL reset_hold_rr: got gnt=%h idx=%0d v=%b up=%b want gnt=00 idx=0 v=0 up=1",
                 gnt_rr, idx_rr, v_rr, up_rr);
      end
      n_vec++;
      if ({gnt_fx, v_fx} !== {8'h00, 1'b0}) begin
        n_err++;
        $display("FAIL reset_hold_fx: got gnt=%h v=%b want gnt=00 v=0", gnt_fx, v_fx);
      end
    end
    reset_n = 1'b1;
    #2;
    n_vec++;
    if (gnt_rr !== 8'h00) begin
      n_err++;
      $display("FAIL reset_release_no_edge: got gnt=%h want 00", gnt_rr);
    end
    cycle();
    n_vec++;
    if ({gnt_rr, idx_rr, v_rr} !== {8'h80, 3'd7, 1'b1}) begin
      n_err++;
      $display("FAIL reset_first_grant: got gnt=%h idx=%0d v=%b want gnt=80 idx=7 v=1",
               gnt_rr, idx_rr, v_rr);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    en  = 1'b1;
    req = 8'b0010_0100;
    cycle();
    n_vec++;
    if ({gnt_fx, idx_fx, v_fx} !== {8'b0010_0000, 3'd5, 1'b1}) begin
      n_err++;
      $display("FAIL fixed_high_wins: got gnt=%b idx=%0d want gnt=00100000 idx=5", gnt_fx, idx_fx);
    end
    req = 8'b0000_0100;
    cycle();
    n_vec++;
    if ({gnt_fx, idx_fx, v_fx} !== {8'b0000_0100, 3'd2, 1'b1}) begin
      n_err++;
      $display("FAIL fixed_release: got gnt=%b idx=%0d want gnt=00000100 idx=2", gnt_fx, idx_fx);
    end
  endtask

  task automatic test_rr_rotation();
    do_reset();
    en  = 1'b1;
    req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      int          want;
      logic [7:0]  wg;
      cycle();
      want = 7 - ((c / MAXH) % N);
      wg   = 8'h01 << want;
      n_vec++;
      if ({gnt_rr, idx_rr, v_rr} !== {wg, 3'(want), 1'b1}) begin
        n_err++;
        $display("FAIL rr_rotation c=%0d: got gnt=%h idx=%0d want gnt=%h idx=%0d",
                 c, gnt_rr, idx_rr, wg, want);
      end
    end
  endtask

  task automatic test_handoff();
    do_reset();
    en  = 1'b1;
    req = 8'h81;
    for (int c = 0; c < 2; c++) begin
      cycle();
      n_vec++;
      if (gnt_rr !== 8'h80) begin
        n_err++;
        $display("FAIL handoff_owner7 c=%0d: got gnt=%h want 80", c, gnt_rr);
      end
    end
    req = 8'h01;
    for (int c = 0; c < 9; c++) begin
      cycle();
      n_vec++;
      if ({gnt_rr, idx_rr} !== {8'h01, 3'd0}) begin
        n_err++;
        $display("FAIL handoff_owner0 c=%0d: got gnt=%h idx=%0d want gnt=01 idx=0", c, gnt_rr, idx_rr);
      end
    end
  endtask

  task automatic test_en_pause();
    do_reset();
    en  = 1'b1;
    req = 8'h08;
    cycle();
    n_vec++;
    if ({gnt_rr, idx_rr} !== {8'h08, 3'd3}) begin
      n_err++;
      $display("FAIL pause_first: got gnt=%h idx=%0d want gnt=08 idx=3", gnt_rr, idx_rr);
    end
    en = 1'b0;
    cycle();
    n_vec++;
    if ({gnt_rr, v_rr, up_rr} !== {8'h00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL pause_off: got gnt=%h v=%b up=%b want gnt=00 v=0 up=1", gnt_rr, v_rr, up_rr);
    end
    en = 1'b1;
    cycle();
    n_vec++;
    if ({gnt_rr, idx_rr, v_rr} !== {8'h08, 3'd3, 1'b1}) begin
      n_err++;
      $display("FAIL pause_regrant: got gnt=%h idx=%0d want gnt=08 idx=3", gnt_rr, idx_rr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    for (int g = 0; g < 3; g++) begin
      req = 8'h04;
      cycle();
      if (g < 2) begin
        req = 8'h00;
        cycle();
      end
    end
    n_vec++;
    if (gnt_rr !== 8'h04) begin
      n_err++;
      $display("FAIL areset_pre_grant: got gnt=%h want 04", gnt_rr);
    end
`ifdef PSEL_PERF_CNT_EN
    n_vec++;
    if (cnt_rr[2*16 +: 16] !== 16'd3) begin
      n_err++;
      $display("FAIL areset_pre_count: got field2=%0d want 3", cnt_rr[2*16 +: 16]);
    end
`endif
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({gnt_rr, idx_rr, v_rr} !== {8'h00, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL areset_immediate: got gnt=%h idx=%0d v=%b want all zero", gnt_rr, idx_rr, v_rr);
    end
`ifdef PSEL_PERF_CNT_EN
    n_vec++;
    if (cnt_rr !== '0) begin
      n_err++;
      $display("FAIL areset_count_clear: got %h want 0", cnt_rr);
    end
`endif
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    en  = 1'b1;
    req = 8'($urandom);
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] flip;
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(7) == 0);
      req = req ^ flip;
      if ($urandom_range(31) == 0) req = '0;
      en = ($urandom_range(15) != 0);
      cycle();
      n_vec++;
      if ({gnt_rr, idx_rr, v_rr} !== exp_out(0)) begin
        n_err++;
        $display("FAIL random_rr c=%0d: got {gnt,idx,v}=%h want %h", c, {gnt_rr, idx_rr, v_rr}, exp_out(0));
      end
      n_vec++;
      if ({gnt_fx, idx_fx, v_fx} !== exp_out(1)) begin
        n_err++;
        $display("FAIL random_fx c=%0d: got {gnt,idx,v}=%h want %h", c, {gnt_fx, idx_fx, v_fx}, exp_out(1));
      end
      n_vec++;
      if ({up_rr, up_fx} !== {2{req != '0}}) begin
        n_err++;
        $display("FAIL random_req_up c=%0d: got %b%b want %b", c, up_rr, up_fx, (req != '0));
      end
    end
`ifdef PSEL_PERF_CNT_EN
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (cnt_rr[i*16 +: 16] !== 16'(m_cnt[i])) begin
        n_err++;
        $display("FAIL random_count[%0d]: got %0d want %0d", i, cnt_rr[i*16 +: 16], m_cnt[i]);
      end
    end
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    req     = '0;
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_handoff();
    test_en_pause();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
